lcd_text_writer: RTL and testbench

Avalon-MM master driving the 16x2 character-LCD controller core: runs the HD44780 power-up command sequence, then converts a stream of ASCII characters into data and command writes. Tracks cursor column and line, wraps lines, and services screen-clear requests. Sits between the Morse decoder's character output and the LCD core's slave port, all in one clock domain.

---
 rtl/lcd_host_pkg.sv | 30 +++
 rtl/lcd_cursor_tracker.sv | 36 +++
 rtl/lcd_text_writer.sv | 159 +++++++++++++++
 tb/tb_lcd_text_writer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_host_pkg.sv
// Shared types and constants for the character-LCD Avalon host.
package lcd_host_pkg;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CMD, ST_DATA} state_t;
   typedef enum logic [1:0] {OP_INIT, OP_CLEAR, OP_NEWLINE} cmd_op_t;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_LINE0    = 8'h80;
   localparam logic [7:0] CMD_LINE1    = 8'hC0;

   localparam logic ADDR_CMD  = 1'b0;
   localparam logic ADDR_DATA = 1'b1;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      cmd = CMD_FUNC_SET;
      case (idx)
         2'd0: cmd = CMD_FUNC_SET;
         2'd1: cmd = CMD_DISP_ON;
         2'd2: cmd = CMD_CLEAR;
         2'd3: cmd = CMD_ENTRY;
         default: cmd = CMD_FUNC_SET;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/lcd_cursor_tracker.sv
// Cursor column/line bookkeeping for a two-line character display.
module lcd_cursor_tracker #(
   parameter int unsigned COLS = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         advance,
   input  logic                         newline,
   input  logic                         home,
   output logic [$clog2(COLS+1)-1:0]    col,
   output logic                         line,
   output logic                         wrap
);
   import lcd_host_pkg::*;

   localparam int unsigned CW = $clog2(COLS + 1);

   // wrap flags that the next advance fills the current line
   assign wrap = (col == CW'(COLS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         col  <= '0;
         line <= 1'b0;
      end else if (home) begin
         col  <= '0;
         line <= 1'b0;
      end else if (newline) begin
         col  <= '0;
         line <= ~line;
      end else if (advance) begin
         col  <= col + CW'(1);
      end
   end

endmodule

// File: rtl/lcd_text_writer.sv
// Avalon-MM master: HD44780 power-up sequence, then ASCII stream to LCD writes.
module lcd_text_writer #(
   parameter int unsigned COLS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   input  logic       clear_req,
   output logic       address,
   output logic       chipselect,
   output logic       read,
   output logic       write,
   output logic [7:0] writedata,
   input  logic [7:0] readdata,
   input  logic       waitrequest,
   output logic       init_done,
   output logic       busy
);
   import lcd_host_pkg::*;

   localparam int unsigned CW = $clog2(COLS + 1);

   state_t     state, state_n;
   cmd_op_t    op, op_n;
   logic [1:0] init_idx, init_idx_n;
   logic       clear_pending, clear_pending_n;
   logic       init_done_n, write_n, address_n;
   logic [7:0] writedata_n;
   logic       advance, newline, home;
   logic [CW-1:0] col;
   logic       line, wrap;
   logic       unused_readdata;

   assign unused_readdata = ^readdata;
   assign read       = 1'b0;
   assign chipselect = write;
   assign busy       = (state != ST_IDLE);
   assign char_ready = (state == ST_IDLE) & init_done & ~clear_req & ~clear_pending;

   lcd_cursor_tracker #(.COLS(COLS)) u_cursor (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .newline (newline),
      .home    (home),
      .col     (col),
      .line    (line),
      .wrap    (wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_INIT;
         op            <= OP_INIT;
         init_idx      <= '0;
         init_done     <= 1'b0;
         clear_pending <= 1'b0;
         write         <= 1'b0;
         address       <= ADDR_CMD;
         writedata     <= '0;
      end else begin
         state         <= state_n;
         op            <= op_n;
         init_idx      <= init_idx_n;
         init_done     <= init_done_n;
         clear_pending <= clear_pending_n;
         write         <= write_n;
         address       <= address_n;
         writedata     <= writedata_n;
      end
   end

   always_comb begin
      state_n         = state;
      op_n            = op;
      init_idx_n      = init_idx;
      init_done_n     = init_done;
      clear_pending_n = clear_pending | clear_req;
      write_n         = write;
      address_n       = address;
      writedata_n     = writedata;
      advance         = 1'b0;
      newline         = 1'b0;
      home            = 1'b0;

      case (state)
         ST_INIT: begin
            write_n     = 1'b1;
            address_n   = ADDR_CMD;
            writedata_n = init_cmd(init_idx);
            op_n        = OP_INIT;
            state_n     = ST_CMD;
         end
         ST_IDLE: begin
            if (clear_req || clear_pending) begin
               write_n         = 1'b1;
               address_n       = ADDR_CMD;
               writedata_n     = CMD_CLEAR;
               op_n            = OP_CLEAR;
               clear_pending_n = 1'b0;
               state_n         = ST_CMD;
            end else if (char_valid && char_ready) begin
               if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                  write_n     = 1'b1;
                  address_n   = ADDR_DATA;
                  writedata_n = char_data;
                  state_n     = ST_DATA;
               end else if (char_data == 8'h0A) begin
                  write_n     = 1'b1;
                  address_n   = ADDR_CMD;
                  writedata_n = line ? CMD_LINE0 : CMD_LINE1;
                  op_n        = OP_NEWLINE;
                  state_n     = ST_CMD;
               end
            end
         end
         ST_CMD: begin
            // a cursor move queued after a line-filling character arrives here with write low
            if (!write) begin
               write_n = 1'b1;
            end else if (!waitrequest) begin
               write_n = 1'b0;
               state_n = ST_IDLE;
               case (op)
                  OP_INIT: begin
                     if (init_idx == 2'd3) begin
                        init_done_n = 1'b1;
                     end else begin
                        init_idx_n = init_idx + 2'd1;
                        state_n    = ST_INIT;
                     end
                  end
                  OP_CLEAR:   home    = 1'b1;
                  OP_NEWLINE: newline = 1'b1;
                  default:    state_n = ST_IDLE;
               endcase
            end
         end
         ST_DATA: begin
            if (!waitrequest) begin
               write_n = 1'b0;
               advance = 1'b1;
               if (wrap) begin
                  address_n   = ADDR_CMD;
                  writedata_n = line ? CMD_LINE0 : CMD_LINE1;
                  op_n        = OP_NEWLINE;
                  state_n     = ST_CMD;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed self-checking bench for lcd_text_writer.
module tb_lcd_text_writer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       char_valid = 1'b0;
   logic [7:0] char_data = 8'h00;
   logic       char_ready;
   logic       clear_req = 1'b0;
   logic       address, chipselect, read, write;
   logic [7:0] writedata;
   logic [7:0] readdata = 8'h00;
   logic       waitrequest = 1'b0;
   logic       init_done, busy;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned last_accept = 0;
   int unsigned t16 = 0;
   logic [8:0]  xq[$];

   lcd_text_writer #(.COLS(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .char_valid  (char_valid),
      .char_data   (char_data),
      .char_ready  (char_ready),
      .clear_req   (clear_req),
      .address     (address),
      .chipselect  (chipselect),
      .read        (read),
      .write       (write),
      .writedata   (writedata),
      .readdata    (readdata),
      .waitrequest (waitrequest),
      .init_done   (init_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // completed transfers, captured mid-cycle
   always @(negedge clk)
      if (!reset && write && !waitrequest) xq.push_back({address, writedata});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_xfer(input string tag, input int idx, input logic [8:0] exp);
      if (idx < xq.size()) check(tag, 32'(xq[idx]), 32'(exp));
      else check(tag, 32'h1FFFF, 32'(exp));
   endtask

   // returns #1 after the edge that follows acceptance
   task automatic send_char(input logic [7:0] c);
      bit ok = 1'b0;
      @(posedge clk); #1;
      char_valid = 1'b1;
      char_data  = c;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (char_ready) begin
            ok = 1'b1;
            last_accept = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      char_valid = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_ready(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (char_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check(tag, 0, 1);
   endtask

   initial begin
      int unsigned prev;
      logic [8:0] e;

      repeat (3) @(posedge clk);
      #1;
      check("rst_write", write, 0);
      check("rst_cs", chipselect, 0);
      check("rst_read", read, 0);
      check("rst_addr", address, 0);
      check("rst_wdata", writedata, 8'h00);
      check("rst_ready", char_ready, 0);
      check("rst_init_done", init_done, 0);
      check("rst_busy", busy, 1);

      reset = 1'b0;
      @(posedge clk); #1;
      check("init_first_write", write, 1);
      check("init_first_data", writedata, 8'h38);
      check("init_first_addr", address, 0);
      repeat (6) @(posedge clk);
      #1;
      check("init_not_yet_done", init_done, 0);
      @(posedge clk); #1;
      check("init_done", init_done, 1);
      check("init_ready", char_ready, 1);
      check("init_busy", busy, 0);
      check("init_count", xq.size(), 4);
      expect_xfer("init_0", 0, 9'h038);
      expect_xfer("init_1", 1, 9'h00C);
      expect_xfer("init_2", 2, 9'h001);
      expect_xfer("init_3", 3, 9'h006);
      xq.delete();

      // 'H' stalled for three cycles
      waitrequest = 1'b1;
      send_char(8'h48);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) waitrequest = 1'b0;
         check("h_write_stable", write, 1);
         check("h_cs_stable", chipselect, 1);
         check("h_data_stable", writedata, 8'h48);
         check("h_addr_stable", address, 1);
         if (k < 3) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      check("h_write_drop", write, 0);
      check("h_ready_back", char_ready, 1);
      send_char(8'h49);
      wait_ready("hi_idle_timeout");
      check("hi_count", xq.size(), 2);
      expect_xfer("hi_0", 0, 9'h148);
      expect_xfer("hi_1", 1, 9'h149);
      check("hi_col", dut.u_cursor.col, 2);
      xq.delete();

      // clear and character in the same IDLE cycle
      @(posedge clk); #1;
      clear_req  = 1'b1;
      char_valid = 1'b1;
      char_data  = 8'h5A;
      @(negedge clk);
      check("clr_blocks_ready", char_ready, 0);
      @(posedge clk); #1;
      clear_req  = 1'b0;
      char_valid = 1'b0;
      send_char(8'h5A);
      wait_ready("z_idle_timeout");
      check("z_count", xq.size(), 2);
      expect_xfer("z_clear", 0, 9'h001);
      expect_xfer("z_data", 1, 9'h15A);
      check("z_col", dut.u_cursor.col, 1);
      check("z_line", dut.u_cursor.line, 0);
      xq.delete();

      // two clear pulses during a stalled write collapse to one clear
      waitrequest = 1'b1;
      send_char(8'h42);
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      @(posedge clk); #1;
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      check("pend_set", dut.clear_pending, 1);
      waitrequest = 1'b0;
      wait_ready("pend_idle_timeout");
      repeat (3) @(posedge clk);
      #1;
      check("pend_count", xq.size(), 2);
      expect_xfer("pend_data", 0, 9'h142);
      expect_xfer("pend_clear", 1, 9'h001);
      check("pend_col", dut.u_cursor.col, 0);
      xq.delete();

      // 32 characters: wrap to line 1, then back to line 0
      prev = 0;
      for (int i = 0; i < 17; i++) begin
         send_char(8'h41);
         if (i == 1) check("plain_char_cycles", last_accept - prev, 2);
         if (i == 15) t16 = last_accept;
         prev = last_accept;
      end
      check("wrap_char_cycles", last_accept - t16, 4);
      wait_ready("a17_idle_timeout");
      check("a17_line", dut.u_cursor.line, 1);
      check("a17_col", dut.u_cursor.col, 1);
      for (int i = 17; i < 32; i++) send_char(8'h41);
      wait_ready("a32_idle_timeout");
      check("a32_count", xq.size(), 34);
      for (int i = 0; i < 34; i++) begin
         e = (i == 16) ? 9'h0C0 : (i == 33) ? 9'h080 : 9'h141;
         expect_xfer("a_seq", i, e);
      end
      check("a32_line", dut.u_cursor.line, 0);
      check("a32_col", dut.u_cursor.col, 0);
      xq.delete();

      // newline then an ignored control code
      send_char(8'h0A);
      send_char(8'h07);
      repeat (5) @(posedge clk);
      #1;
      check("nl_count", xq.size(), 1);
      expect_xfer("nl_cmd", 0, 9'h0C0);
      check("nl_line", dut.u_cursor.line, 1);
      check("nl_col", dut.u_cursor.col, 0);
      check("bel_idle", busy, 0);
      xq.delete();

      // reset during a stalled write
      waitrequest = 1'b1;
      send_char(8'h51);
      check("q_write", write, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_write", write, 0);
      check("mid_rst_init_done", init_done, 0);
      check("mid_rst_line", dut.u_cursor.line, 0);
      waitrequest = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      check("restart_write", write, 1);
      check("restart_data", writedata, 8'h38);
      check("restart_addr", address, 0);
      check("restart_no_xfer", xq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
